dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: fixed-latency load/store handshake
// in front of a small 64-bit word store, with alignment and range checking.
module dmem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DATA_W = 64;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_busy;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_err;
  logic              w_mem_we;
  logic [AW-1:0]     w_idx;

  // Errored requests must never touch storage, including aliasing of
  // out-of-range addresses onto the low word index bits.
  assign w_accept = req_valid & r_req_ready;
  assign w_idx    = req_addr[AW+2:3];
  assign w_err    = (req_addr[2:0] != 3'b000) | (|req_addr[63:AW+3]);
  assign w_mem_we = w_accept & req_write & ~w_err & ~reset;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (!req_write && !w_err) ? r_mem[w_idx] : '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (LATENCY == 1) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_cnt       <= 4'd0;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_cnt       <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          // Accept is blocked this cycle; the next request is taken from IDLE.
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= 4'd0;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 1, 4) share a
// clock and are exercised with hand-computed load/store vectors.
module tb_dmem_responder;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 4;
  endfunction

  logic             clk = 1'b0;
  logic [2:0]       reset;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0]       req_write;
  logic [2:0][63:0] req_addr;
  logic [2:0][63:0] req_wdata;
  logic [2:0]       rsp_valid;
  logic [2:0]       rsp_ready;
  logic [2:0][63:0] rsp_rdata;
  logic [2:0]       rsp_err;
  logic [2:0]       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.LATENCY(lat_of(g)), .DEPTH(32)) u_dut (
      .clk      (clk),
      .reset    (reset[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_write(req_write[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g]),
      .busy     (busy[g])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (!req_ready[d] && n < 20) begin
      tick();
      n++;
    end
    check_eq("req_ready_idle", 64'(req_ready[d]), 64'd1);
  endtask

  // One full transaction; hold>0 keeps rsp_ready low for that many cycles
  // after rsp_valid rises. Request fields are scrambled after the accept edge.
  task automatic do_req(input int d, input bit wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input int hold,
                        output logic [63:0] rd, output logic e, output int acc);
    int n;
    wait_ready(d);
    rsp_ready[d] = (hold == 0);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    tick();
    acc = cyc;
    req_valid[d] = 1'b0;
    req_write[d] = ~wr;
    req_addr[d]  = ~addr;
    req_wdata[d] = ~wdata;
    check_eq("busy_after_accept", 64'(busy[d]), 64'd1);
    check_eq("req_ready_after_accept", 64'(req_ready[d]), 64'd0);
    n = 1;
    while (!rsp_valid[d] && n < 40) begin
      tick();
      n++;
    end
    check_eq("latency", 64'(n), 64'(lat_of(d)));
    rd = rsp_rdata[d];
    e  = rsp_err[d];
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("bp_rsp_valid", 64'(rsp_valid[d]), 64'd1);
      check_eq("bp_rsp_rdata", rsp_rdata[d], rd);
      check_eq("bp_rsp_err", 64'(rsp_err[d]), 64'(e));
      check_eq("bp_req_ready", 64'(req_ready[d]), 64'd0);
    end
    rsp_ready[d] = 1'b1;
    tick();
    check_eq("consumed_rsp_valid", 64'(rsp_valid[d]), 64'd0);
    check_eq("consumed_req_ready", 64'(req_ready[d]), 64'd1);
    check_eq("consumed_busy", 64'(busy[d]), 64'd0);
  endtask

  task automatic store_ok(input int d, input logic [63:0] addr, input logic [63:0] data);
    logic [63:0] rd;
    logic e;
    int acc;
    do_req(d, 1'b1, addr, data, 0, rd, e, acc);
    check_eq("store_rdata", rd, 64'd0);
    check_eq("store_err", 64'(e), 64'd0);
  endtask

  task automatic load_expect(input int d, input logic [63:0] addr,
                             input logic [63:0] exp_data, input bit exp_err);
    logic [63:0] rd;
    logic e;
    int acc;
    do_req(d, 1'b0, addr, 64'd0, 0, rd, e, acc);
    check_eq("load_rdata", rd, exp_data);
    check_eq("load_err", 64'(e), 64'(exp_err));
  endtask

  // Store is committed on its accept edge; reset in WAIT drops the response.
  task automatic reset_mid(input int d, input logic [63:0] addr, input logic [63:0] data);
    bit seen = 1'b0;
    wait_ready(d);
    rsp_ready[d] = 1'b1;
    req_valid[d] = 1'b1;
    req_write[d] = 1'b1;
    req_addr[d]  = addr;
    req_wdata[d] = data;
    tick();
    req_valid[d] = 1'b0;
    reset[d] = 1'b1;
    tick();
    reset[d] = 1'b0;
    check_eq("rst_mid_req_ready", 64'(req_ready[d]), 64'd1);
    check_eq("rst_mid_busy", 64'(busy[d]), 64'd0);
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid[d]) seen = 1'b1;
      tick();
    end
    check_eq("rst_mid_no_response", 64'(seen), 64'd0);
    check_eq("rst_mid_req_ready_later", 64'(req_ready[d]), 64'd1);
  endtask

  initial begin
    logic [63:0] rd;
    logic e;
    int a1;
    int a2;

    reset     = '1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = '1;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      check_eq("rst_rsp_valid", 64'(rsp_valid[d]), 64'd0);
      check_eq("rst_rsp_rdata", rsp_rdata[d], 64'd0);
      check_eq("rst_rsp_err", 64'(rsp_err[d]), 64'd0);
      check_eq("rst_busy", 64'(busy[d]), 64'd0);
      check_eq("rst_req_ready", 64'(req_ready[d]), 64'd1);
    end
    reset = '0;
    tick();

    // LATENCY=2 instance
    store_ok(0, 64'h10, 64'hDEAD_BEEF);
    load_expect(0, 64'h10, 64'hDEAD_BEEF, 1'b0);
    store_ok(0, 64'h0, 64'd5);
    load_expect(0, 64'h13, 64'd0, 1'b1);
    load_expect(0, 64'h100, 64'd0, 1'b1);
    load_expect(0, 64'h8000_0000_0000_0000, 64'd0, 1'b1);
    load_expect(0, 64'h0, 64'd5, 1'b0);

    do_req(0, 1'b0, 64'h10, 64'd0, 4, rd, e, a1);
    check_eq("bp_load_rdata", rd, 64'hDEAD_BEEF);
    check_eq("bp_load_err", 64'(e), 64'd0);

    reset_mid(0, 64'h20, 64'h7);
    load_expect(0, 64'h20, 64'h7, 1'b0);

    do_req(0, 1'b1, 64'h21, 64'h99, 0, rd, e, a1);
    check_eq("bad_store_err", 64'(e), 64'd1);
    check_eq("bad_store_rdata", rd, 64'd0);
    load_expect(0, 64'h20, 64'h7, 1'b0);

    do_req(0, 1'b1, 64'h100, 64'h55, 0, rd, e, a1);
    check_eq("oor_store_err", 64'(e), 64'd1);
    load_expect(0, 64'h0, 64'd5, 1'b0);

    store_ok(0, 64'hF8, 64'h1234);
    load_expect(0, 64'hF8, 64'h1234, 1'b0);
    load_expect(0, 64'h0, 64'd5, 1'b0);

    // LATENCY=1 instance: back-to-back loads accepted every two cycles
    store_ok(1, 64'h8, 64'h1111_0000_0000_0001);
    store_ok(1, 64'h18, 64'h2222_0000_0000_0002);
    do_req(1, 1'b0, 64'h8, 64'd0, 0, rd, e, a1);
    check_eq("l1_load0_rdata", rd, 64'h1111_0000_0000_0001);
    do_req(1, 1'b0, 64'h18, 64'd0, 0, rd, e, a2);
    check_eq("l1_load1_rdata", rd, 64'h2222_0000_0000_0002);
    check_eq("l1_accept_spacing", 64'(a2 - a1), 64'd2);

    // LATENCY=4 instance: reset wins over a simultaneous store
    store_ok(2, 64'h40, 64'hAA);
    wait_ready(2);
    reset[2]     = 1'b1;
    req_valid[2] = 1'b1;
    req_write[2] = 1'b1;
    req_addr[2]  = 64'h40;
    req_wdata[2] = 64'hBB;
    tick();
    reset[2]     = 1'b0;
    req_valid[2] = 1'b0;
    check_eq("rst_prio_busy", 64'(busy[2]), 64'd0);
    check_eq("rst_prio_req_ready", 64'(req_ready[2]), 64'd1);
    load_expect(2, 64'h40, 64'hAA, 1'b0);
    reset_mid(2, 64'h20, 64'h7);
    load_expect(2, 64'h20, 64'h7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
